// File: rtl/mac_src_feeder.sv
// Operand sequencer for one MAC lane: takes a job length, streams operand pairs to the MAC, flags the result.
// Latency: operand handshake -> src_vld 1 cycle; last src_vld/clear -> done_vld after MAC_LAT cycles.
// Backpressure: in_rdy only in FEED, cmd_rdy only in IDLE; both decoded from state, no path from the valids.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy/cmd_len        job command (cmd_len = products, 0 = clear-only job)
//   in_vld/in_rdy/in_src_0/1       upstream operand-pair stream
//   init/clear/src_vld/src_0/1     registered drive into the MAC
//   done_vld                       one-cycle pulse: MAC acc holds the job result
//   busy                           job in progress
module mac_src_feeder #(
   parameter int unsigned SRC0_W  = 10,
   parameter int unsigned SRC1_W  = 8,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned MAC_LAT = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_vld,
   output logic              cmd_rdy,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [SRC0_W-1:0] in_src_0,
   input  logic [SRC1_W-1:0] in_src_1,
   output logic              init,
   output logic              clear,
   output logic              src_vld,
   output logic [SRC0_W-1:0] src_0,
   output logic [SRC1_W-1:0] src_1,
   output logic              done_vld,
   output logic              busy
);

   localparam int unsigned WCNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CLR  = 2'd1,
      S_FEED = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [LEN_W-1:0]    remaining, remaining_nxt;
   logic                first, first_nxt;
   logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
   logic                init_nxt, clear_nxt, src_vld_nxt, done_nxt;
   logic [SRC0_W-1:0]   src_0_nxt;
   logic [SRC1_W-1:0]   src_1_nxt;

   assign cmd_rdy = (state == S_IDLE);
   assign in_rdy  = (state == S_FEED);
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         remaining <= '0;
         first     <= 1'b0;
         wcnt      <= '0;
         init      <= 1'b0;
         clear     <= 1'b0;
         src_vld   <= 1'b0;
         src_0     <= '0;
         src_1     <= '0;
         done_vld  <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         first     <= first_nxt;
         wcnt      <= wcnt_nxt;
         init      <= init_nxt;
         clear     <= clear_nxt;
         src_vld   <= src_vld_nxt;
         src_0     <= src_0_nxt;
         src_1     <= src_1_nxt;
         done_vld  <= done_nxt;
      end
   end

   // wcnt counts down from MAC_LAT starting in the cycle the last MAC event
   // (final src_vld, or clear) is visible at the MAC; done_vld is raised when
   // it reaches 1 so the pulse lands exactly MAC_LAT cycles after that event.
   // For a clear-only job that event cycle is CLR itself, so the count is
   // loaded at the command handshake and CLR decrements it like WAIT does.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      first_nxt     = first;
      wcnt_nxt      = wcnt;
      init_nxt      = 1'b0;
      clear_nxt     = 1'b0;
      src_vld_nxt   = 1'b0;
      src_0_nxt     = src_0;
      src_1_nxt     = src_1;
      done_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            if (cmd_vld) begin
               if (cmd_len == '0) begin
                  state_nxt = S_CLR;
                  clear_nxt = 1'b1;
                  wcnt_nxt  = WCNT_W'(MAC_LAT);
               end else begin
                  state_nxt     = S_FEED;
                  remaining_nxt = cmd_len;
                  first_nxt     = 1'b1;
               end
            end
         end

         S_CLR: begin
            done_nxt  = (wcnt == WCNT_W'(1));
            wcnt_nxt  = wcnt - WCNT_W'(1);
            state_nxt = S_WAIT;
         end

         S_FEED: begin
            if (in_vld) begin
               src_vld_nxt   = 1'b1;
               src_0_nxt     = in_src_0;
               src_1_nxt     = in_src_1;
               init_nxt      = first;
               first_nxt     = 1'b0;
               remaining_nxt = remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) begin
                  state_nxt = S_WAIT;
                  wcnt_nxt  = WCNT_W'(MAC_LAT);
               end
            end
         end

         S_WAIT: begin
            if (done_vld) begin
               state_nxt = S_IDLE;
            end else begin
               done_nxt = (wcnt == WCNT_W'(1));
               if (wcnt != '0) begin
                  wcnt_nxt = wcnt - WCNT_W'(1);
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
